// File: rtl/mc_defs_pkg.sv
// Shared DDR4 scheduler definitions: command/op encodings, address
// field positions and default DRAM timing values.
package mc_defs;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    OP_RD     = 2'd0,
    OP_WR     = 2'd1,
    OP_IFETCH = 2'd2,
    OP_ILL    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RP,
    S_WAIT_RCD,
    S_DATA
  } state_e;

  localparam int ROW_MSB  = 31;
  localparam int ROW_LSB  = 18;
  localparam int HCOL_MSB = 17;
  localparam int HCOL_LSB = 10;
  localparam int BA_MSB   = 9;
  localparam int BA_LSB   = 8;
  localparam int BG_MSB   = 7;
  localparam int BG_LSB   = 6;
  localparam int LCOL_MSB = 5;
  localparam int LCOL_LSB = 3;

  localparam int BANK_W = 4;
  localparam int ROW_W  = 14;
  localparam int COL_W  = 11;

  localparam int unsigned DEF_T_RP    = 24;
  localparam int unsigned DEF_T_RCD   = 24;
  localparam int unsigned DEF_T_RAS   = 52;
  localparam int unsigned DEF_T_CL    = 24;
  localparam int unsigned DEF_T_BURST = 4;

  function automatic logic is_wr(input logic [1:0] op);
    return op == OP_WR;
  endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// Open-row table for all 16 banks plus per-bank saturating tRAS
// counters; answers hit/open/ras_ok for the queried bank.
module ddr4_bank_tracker
  import mc_defs::*;
#(
  parameter int unsigned T_RAS = DEF_T_RAS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic              pre,
  input  logic [BANK_W-1:0] idx,
  input  logic [ROW_W-1:0]  row,
  output logic              hit,
  output logic              open,
  output logic              ras_ok
);

  localparam int NB = 1 << BANK_W;
  localparam logic [7:0] RAS8 = 8'(T_RAS);

  logic [NB-1:0]    open_q;
  logic [ROW_W-1:0] row_q [NB];
  logic [7:0]       ras_q [NB];

  // Counter reads k in the k-th cycle after ACT; 8'hff means long ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NB; i++) begin
        row_q[i] <= '0;
        ras_q[i] <= 8'hff;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (act && idx == BANK_W'(i)) begin
          ras_q[i] <= 8'd1;
        end else if (ras_q[i] != 8'hff) begin
          ras_q[i] <= ras_q[i] + 8'd1;
        end
      end
      if (act) begin
        open_q[idx] <= 1'b1;
        row_q[idx]  <= row;
      end else if (pre) begin
        open_q[idx] <= 1'b0;
      end
    end
  end

  assign open   = open_q[idx];
  assign hit    = open_q[idx] && (row_q[idx] == row);
  assign ras_ok = ras_q[idx] >= RAS8;

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// In-order DDR4 command scheduler: one request at a time, open-page
// policy, issues PRE/ACT/RD/WR and pulses done at end of burst.
module ddr4_cmd_scheduler
  import mc_defs::*;
#(
  parameter int unsigned T_RP    = DEF_T_RP,
  parameter int unsigned T_RCD   = DEF_T_RCD,
  parameter int unsigned T_RAS   = DEF_T_RAS,
  parameter int unsigned T_CL    = DEF_T_CL,
  parameter int unsigned T_BURST = DEF_T_BURST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        cmd_valid,
  output cmd_e        cmd,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [13:0] cmd_row,
  output logic [10:0] cmd_col,
  output logic        done_valid,
  output logic [1:0]  done_op,
  output logic        busy
);

  localparam logic [8:0] RP_L  = 9'(T_RP - 1);
  localparam logic [8:0] RCD_L = 9'(T_RCD - 1);
  localparam logic [8:0] DAT_L = 9'(T_CL + T_BURST - 1);

  state_e state_q, state_d;
  logic [8:0] wait_q, wait_d;

  logic [1:0]       op_q;
  logic [ROW_W-1:0] row_q;
  logic [1:0]       bg_q, ba_q;
  logic [COL_W-1:0] col_q;

  logic [ROW_W-1:0] hrow_q;
  logic [1:0]       hbg_q, hba_q;
  logic [COL_W-1:0] hcol_q;

  logic fire, act, pre, hit, bank_open, ras_ok;
  cmd_e col_cmd, cmd_c;
  logic unused;

  assign unused = ^req_addr[2:0];
  assign fire   = req_valid && (state_q == S_IDLE);

  ddr4_bank_tracker #(.T_RAS(T_RAS)) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .act    (act),
    .pre    (pre),
    .idx    ({bg_q, ba_q}),
    .row    (row_q),
    .hit    (hit),
    .open   (bank_open),
    .ras_ok (ras_ok)
  );

  assign col_cmd = is_wr(op_q) ? CMD_WR : CMD_RD;

  always_comb begin
    state_d    = state_q;
    wait_d     = (wait_q != 9'd0) ? wait_q - 9'd1 : 9'd0;
    cmd_c      = CMD_NOP;
    act        = 1'b0;
    pre        = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (hit) begin
          cmd_c   = col_cmd;
          wait_d  = DAT_L;
          state_d = S_DATA;
        end else if (!bank_open) begin
          cmd_c   = CMD_ACT;
          act     = 1'b1;
          wait_d  = RCD_L;
          state_d = S_WAIT_RCD;
        end else if (ras_ok) begin
          cmd_c   = CMD_PRE;
          pre     = 1'b1;
          wait_d  = RP_L;
          state_d = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (wait_q == 9'd0) begin
          cmd_c   = CMD_ACT;
          act     = 1'b1;
          wait_d  = RCD_L;
          state_d = S_WAIT_RCD;
        end
      end
      S_WAIT_RCD: begin
        if (wait_q == 9'd0) begin
          cmd_c   = col_cmd;
          wait_d  = DAT_L;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wait_q == 9'd0) begin
          done_valid = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
      row_q   <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
      col_q   <= '0;
      hrow_q  <= '0;
      hbg_q   <= '0;
      hba_q   <= '0;
      hcol_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (fire) begin
        assert (req_op != OP_ILL)
          else $error("ddr4_cmd_scheduler: illegal op 3");
        op_q  <= req_op;
        row_q <= req_addr[ROW_MSB:ROW_LSB];
        bg_q  <= req_addr[BG_MSB:BG_LSB];
        ba_q  <= req_addr[BA_MSB:BA_LSB];
        col_q <= {req_addr[HCOL_MSB:HCOL_LSB],
                  req_addr[LCOL_MSB:LCOL_LSB]};
      end
      if (cmd_valid) begin
        hrow_q <= row_q;
        hbg_q  <= bg_q;
        hba_q  <= ba_q;
        hcol_q <= col_q;
      end
    end
  end

  assign cmd_valid = (cmd_c != CMD_NOP);
  assign cmd       = cmd_c;
  assign cmd_bg    = cmd_valid ? bg_q  : hbg_q;
  assign cmd_ba    = cmd_valid ? ba_q  : hba_q;
  assign cmd_row   = cmd_valid ? row_q : hrow_q;
  assign cmd_col   = cmd_valid ? col_q : hcol_q;
  assign done_op   = done_valid ? op_q : 2'd0;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: directed and random requests on two
// instances (default timing, and long tRAS / short tCL).
module tb_ddr4_cmd_scheduler;
  import mc_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic        cmd_valid [2];
  logic [2:0]  cmd       [2];
  logic [1:0]  cmd_bg    [2];
  logic [1:0]  cmd_ba    [2];
  logic [13:0] cmd_row   [2];
  logic [10:0] cmd_col   [2];
  logic        done_valid[2];
  logic [1:0]  done_op   [2];
  logic        busy      [2];

  ddr4_cmd_scheduler u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]),
    .cmd_valid(cmd_valid[0]), .cmd(cmd[0]),
    .cmd_bg(cmd_bg[0]), .cmd_ba(cmd_ba[0]),
    .cmd_row(cmd_row[0]), .cmd_col(cmd_col[0]),
    .done_valid(done_valid[0]), .done_op(done_op[0]),
    .busy(busy[0])
  );

  ddr4_cmd_scheduler #(.T_RAS(100), .T_CL(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1]),
    .cmd_valid(cmd_valid[1]), .cmd(cmd[1]),
    .cmd_bg(cmd_bg[1]), .cmd_ba(cmd_ba[1]),
    .cmd_row(cmd_row[1]), .cmd_col(cmd_col[1]),
    .done_valid(done_valid[1]), .done_op(done_op[1]),
    .busy(busy[1])
  );

  int p_rp [2] = '{24, 24};
  int p_rcd[2] = '{24, 24};
  int p_ras[2] = '{52, 100};
  int p_cl [2] = '{24, 4};
  int p_bl = 4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [2:0]  c;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] row;
    logic [10:0] col;
  } ev_t;

  ev_t        evq[2][$];
  int         done_n[2];
  int         done_t[2];
  logic [1:0] done_o[2];

  // Reference bank state, per instance.
  logic bopen[2][16];
  int   brow [2][16];
  int   bact [2][16];

  always @(negedge clk) begin
    ev_t e;
    for (int d = 0; d < 2; d++) begin
      if (cmd_valid[d]) begin
        e.t = cyc; e.c = cmd[d]; e.bg = cmd_bg[d]; e.ba = cmd_ba[d];
        e.row = cmd_row[d]; e.col = cmd_col[d];
        evq[d].push_back(e);
      end else begin
        tests++;
        assert (cmd[d] === 3'd0) else begin
          fails++;
          $error("FAIL nop_when_idle dut%0d got %0d exp 0", d, cmd[d]);
        end
      end
      if (done_valid[d]) begin
        done_n[d]++;
        done_t[d] = cyc;
        done_o[d] = done_op[d];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 16; b++) begin
        bopen[d][b] = 1'b0; brow[d][b] = 0; bact[d][b] = -1000;
      end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_req_ready", 32'(req_ready[d]), 1);
    chk("rst_cmd_valid", 32'(cmd_valid[d]), 0);
    chk("rst_cmd", 32'(cmd[d]), 0);
    chk("rst_cmd_bg", 32'(cmd_bg[d]), 0);
    chk("rst_cmd_ba", 32'(cmd_ba[d]), 0);
    chk("rst_cmd_row", 32'(cmd_row[d]), 0);
    chk("rst_cmd_col", 32'(cmd_col[d]), 0);
    chk("rst_done_valid", 32'(done_valid[d]), 0);
    chk("rst_done_op", 32'(done_op[d]), 0);
    chk("rst_busy", 32'(busy[d]), 0);
  endtask

  task automatic run_req(input int d, input logic [1:0] op,
                         input logic [31:0] a);
    int n, t, s, p, ne, dn, k;
    int et[3];
    logic [2:0] ec[3];
    logic [3:0] bk;
    logic [13:0] r;
    logic [10:0] col;
    logic [2:0] cc;
    n = 0;
    while (!req_ready[d] && n < 500) begin tick(); n++; end
    chk("ready_before_req", 32'(req_ready[d]), 1);
    evq[d].delete();
    done_n[d] = 0;
    req_op[d] = op; req_addr[d] = a; req_valid[d] = 1'b1;
    t = cyc;
    tick();
    req_valid[d] = 1'b0;
    chk("busy_in_issue", 32'(busy[d]), 1);
    bk  = {a[7:6], a[9:8]};
    r   = a[31:18];
    col = {a[17:10], a[5:3]};
    cc  = (op == 2'd1) ? 3'd3 : 3'd2;
    s   = t + 1;
    if (bopen[d][bk] && brow[d][bk] == int'(r)) begin
      ne = 1; et[0] = s; ec[0] = cc;
    end else if (!bopen[d][bk]) begin
      ne = 2;
      et[0] = s; ec[0] = 3'd1;
      et[1] = s + p_rcd[d]; ec[1] = cc;
      bact[d][bk] = s;
    end else begin
      p = bact[d][bk] + p_ras[d];
      if (p < s) p = s;
      ne = 3;
      et[0] = p; ec[0] = 3'd4;
      et[1] = p + p_rp[d]; ec[1] = 3'd1;
      et[2] = p + p_rp[d] + p_rcd[d]; ec[2] = cc;
      bact[d][bk] = p + p_rp[d];
    end
    bopen[d][bk] = 1'b1;
    brow[d][bk]  = int'(r);
    dn = et[ne-1] + p_cl[d] + p_bl;
    n = 0;
    while (done_n[d] == 0 && n < 1000) begin tick(); n++; end
    chk("done_cycle", done_t[d], dn);
    chk("done_op", 32'(done_o[d]), 32'(op));
    chk("ready_low_at_done", 32'(req_ready[d]), 0);
    tick();
    chk("ready_after_done", 32'(req_ready[d]), 1);
    chk("done_count", done_n[d], 1);
    chk("cmd_count", evq[d].size(), ne);
    k = (evq[d].size() < ne) ? evq[d].size() : ne;
    for (int i = 0; i < k; i++) begin
      chk("cmd_cycle", evq[d][i].t, et[i]);
      chk("cmd_kind", 32'(evq[d][i].c), 32'(ec[i]));
      chk("cmd_bg", 32'(evq[d][i].bg), 32'(a[7:6]));
      chk("cmd_ba", 32'(evq[d][i].ba), 32'(a[9:8]));
      if (ec[i] == 3'd1) chk("cmd_row", 32'(evq[d][i].row), 32'(r));
      if (ec[i] == 3'd2 || ec[i] == 3'd3)
        chk("cmd_col", 32'(evq[d][i].col), 32'(col));
    end
  endtask

  initial begin
    logic [13:0] rr;
    logic [7:0]  hc;
    logic [2:0]  lc;
    logic [1:0]  rba, rbg, rop;
    int d, n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = '0; req_addr[i] = '0;
      done_n[i] = 0; done_t[i] = 0; done_o[i] = '0;
    end
    model_reset();
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Cold read, row hit write, conflict, return to row 1.
    run_req(0, 2'd0, 32'h0004_0000);
    run_req(0, 2'd1, 32'h0004_0008);
    run_req(0, 2'd0, 32'h0008_0000);
    run_req(0, 2'd2, 32'h0004_0000);
    // Other bank: ACT only, then bank 0 row 1 still hits.
    run_req(0, 2'd1, 32'h0014_0240);
    run_req(0, 2'd0, 32'h0004_0010);

    // Long tRAS: conflict right after completion stalls until ACT+100.
    run_req(1, 2'd0, 32'h0004_0000);
    run_req(1, 2'd0, 32'h0008_0000);
    run_req(1, 2'd1, 32'h0008_0040);

    // Reset while waiting tRCD.
    evq[0].delete();
    done_n[0] = 0;
    req_op[0] = 2'd0; req_addr[0] = 32'h001C_0380; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    repeat (5) tick();
    chk("act_before_reset", evq[0].size(), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (n < 60) begin tick(); n++; end
    chk("no_done_after_reset", done_n[0], 0);
    run_req(0, 2'd0, 32'h001C_0380);
    run_req(0, 2'd0, 32'h0004_0000);

    // Random traffic on a few rows/banks to mix hits and conflicts.
    for (int i = 0; i < 40; i++) begin
      d   = i % 2;
      rr  = 14'($urandom_range(0, 3));
      hc  = 8'($urandom);
      lc  = 3'($urandom);
      rba = 2'($urandom_range(0, 1));
      rbg = 2'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) tick();
      run_req(d, rop, {rr, hc, rba, rbg, lc, 3'b000});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_scheduler.md
Name: ddr4_cmd_scheduler

Overview:
- In-order DDR4 command scheduler placed between the controller's 16-entry request queue and the DRAM command bus model.
- Accepts one request at a time from the queue head and decodes its address into row, bank group, bank and column.
- Tracks open rows for all 16 banks (open-page policy) and issues PRE, ACT, RD or WR while honouring tRP, tRCD, tRAS, tCL and tBURST.
- Pulses a completion when the data burst finishes.

Parameters:
- T_RP, 24, PRE to ACT (same bank), DRAM clocks.
- T_RCD, 24, ACT to RD/WR (same bank).
- T_RAS, 52, ACT to PRE (same bank).
- T_CL, 24, column command to first data.
- T_BURST, 4, burst duration (BL8).
- All timing values are restricted to the range 1..255.

Ports:
- clk  in  1  scheduler clock; one tick = one DRAM clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  queue head holds a valid request.
- req_ready  out  1  scheduler can accept a request.
- req_op  in  2  0=read, 1=write, 2=ifetch (treated as read); 3 is illegal.
- req_addr  in  32  row[31:18], hcol[17:10], ba[9:8], bg[7:6], lcol[5:3], [2:0] ignored.
- cmd_valid  out  1  one-cycle command strobe.
- cmd  out  3  cmd_e: NOP=0, ACT=1, RD=2, WR=3, PRE=4.
- cmd_bg  out  2  target bank group.
- cmd_ba  out  2  target bank.
- cmd_row  out  14  row; valid on ACT.
- cmd_col  out  11  {hcol, lcol}; valid on RD/WR.
- done_valid  out  1  one-cycle pulse at end of data burst.
- done_op  out  2  op of the completed request.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: req_ready=1, cmd_valid=0, cmd=NOP, all cmd fields 0, done_valid=0, done_op=0, busy=0.
  - All 16 banks closed; all timing counters saturated (constraints met).
- Reset asserted mid-operation aborts the request immediately; no done pulse is produced.
- Handshake: transfer on a rising edge with req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched at transfer.
- FSM states and transitions:
  - IDLE: goes to ISSUE on transfer.
  - ISSUE: evaluates the latched bank (index = {bg, ba}).
    - Hit (bank open, row matches): issue RD (op 0/2) or WR (op 1) this cycle, load wait counter with T_CL+T_BURST-1, go to DATA.
    - Closed bank: issue ACT, mark the bank open with the row, start its tRAS counter, go to WAIT_RCD.
    - Conflict (bank open, row differs): stall in ISSUE, cmd=NOP, until the bank's tRAS has elapsed. Then issue PRE, mark the bank closed, go to WAIT_RP.
  - WAIT_RP: after T_RP cycles counted from the PRE cycle, issue ACT in the cycle that equals PRE+T_RP, go to WAIT_RCD.
  - WAIT_RCD: at ACT+T_RCD, issue RD/WR, go to DATA.
  - DATA: done_valid=1 and done_op=latched op in the cycle equal to COL+T_CL+T_BURST, then go to IDLE. req_ready rises in the following cycle.
- Latency from transfer cycle A:
  - Hit: COL at A+1, done at A+1+T_CL+T_BURST.
  - Closed bank: ACT at A+1, COL at A+1+T_RCD.
  - Conflict: PRE at max(A+1, lastACT+T_RAS).
- Command rules:
  - At most one command per cycle.
  - cmd fields hold their last values when cmd_valid=0; cmd=NOP whenever cmd_valid=0.
- tCCD is implied: no two column commands can be closer than T_CL+T_BURST.
- Per-bank tRAS counter: 8-bit, loaded on ACT, saturates. PRE is allowed in cycle ≥ ACT+T_RAS.
- Timing compares use 8-bit unsigned counters; no wrap-around is possible because counters saturate.
- Illegal op 3: the request is accepted and completes as a read, and an error message is emitted (simulation-only assertion).
- Out of scope: refresh and power-down.

Decomposition:
- mc_defs package holds:
  - cmd_e and op_e typedefs.
  - Address field slice constants: ROW_MSB/LSB, HCOL, BA, BG, LCOL.
  - Default timing constants.
  - The bank index width (4).
- One sub-module, ddr4_bank_tracker, owns the 16-entry open flag and row table plus the per-bank tRAS counters.
  - Inputs: act/pre strobes with bank index and row.
  - Outputs: hit, open and ras_ok for the queried bank.

Test Plan:
- Cold read, addr 0x0004_0000 (row 1, bank 0), transfer at A -> ACT row 1 at A+1, RD at A+25, done_valid op 0 at A+53, req_ready at A+54.
- Row hit: write to 0x0004_0008 accepted at B after the first access -> WR col 1 at B+1, done at B+29, no ACT or PRE.
- Row conflict: read of 0x0008_0000 (row 2, bank 0) accepted at A+54 -> PRE at A+55, ACT row 2 at A+79, RD at A+103, done at A+131.
- tRAS stall with T_RAS=100, T_CL=4: conflict request right after a hit completes -> NOP in ISSUE until PRE at ACT+100.
- Bank independence: bank 0 row 1 open, then request to bg 1, ba 2 row 5 -> ACT without PRE; bank 0 stays open and a later row-1 access hits.
- Reset asserted in WAIT_RCD -> all outputs at reset values immediately, no done pulse, next access to the same row issues ACT (banks closed).
